// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and op-class decode.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // One bit per op code; set where the op runs through the iterative unit.
  localparam logic [7:0] ITER_OP_MASK = 8'b0001_1100;
  localparam logic [7:0] DIV_OP_MASK  = 8'b0001_1000;

  function automatic logic is_iterative(input op_t op);
    return ITER_OP_MASK[op];
  endfunction

  function automatic logic is_divide(input op_t op);
    return DIV_OP_MASK[op];
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared N-step shift/accumulate datapath: shift-add multiply (div_mode=0)
// or restoring division (div_mode=1). acc_hi/acc_lo present the post-step value.
module alu_iter_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         div_mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] acc_hi,
  output logic [N-1:0] acc_lo
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  b_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    mul_sum;
  logic [2*N-1:0] mul_nxt;
  logic [N:0]    rem_shift;
  logic [N-1:0]  quo_shift;
  logic          rem_ge;

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, b_q};
    // Multiplier sits in lo and drains out the bottom as the product fills in.
    mul_nxt   = lo_q[0] ? {mul_sum, lo_q[N-1:1]} : {1'b0, hi_q, lo_q[N-1:1]};
    rem_shift = {hi_q, lo_q[N-1]};
    quo_shift = {lo_q[N-2:0], 1'b0};
    rem_ge    = (rem_shift >= {1'b0, b_q});
    acc_hi    = '0;
    acc_lo    = '0;
    if (mode_q) begin
      if (rem_ge) begin
        acc_hi = rem_shift[N-1:0] - b_q;
        acc_lo = {quo_shift[N-1:1], 1'b1};
      end else begin
        acc_hi = rem_shift[N-1:0];
        acc_lo = quo_shift;
      end
    end else begin
      acc_hi = mul_nxt[2*N-1:N];
      acc_lo = mul_nxt[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      mode_q <= div_mode;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= acc_hi;
      lo_q   <= acc_lo;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake, registered results and N/Z/C/V flags.
//   state | meaning
//   IDLE  | waiting for start; outputs hold last completion
//   EXEC  | operation in flight; single-step ops finish on first edge
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err_div0
);

  state_t       state_q, state_nxt;
  op_t          op_q;
  logic [N-1:0] a_q, b_q;

  logic         accept, finish, step, div0, iter_last;
  logic [N-1:0] iter_hi, iter_lo;
  logic [N:0]   add_full, sub_full;
  logic [N-1:0] res_nxt, hi_nxt;
  logic         n_nxt, z_nxt, c_nxt, v_nxt, err_nxt;

  alu_iter_unit #(.N(N)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (step),
    .div_mode (is_divide(op_t'(op))),
    .a        (a),
    .b        (b),
    .last     (iter_last),
    .acc_hi   (iter_hi),
    .acc_lo   (iter_lo)
  );

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  assign div0     = is_divide(op_q) && (b_q == '0);
  assign busy     = (state_q == EXEC);

  always_comb begin
    res_nxt = '0;
    hi_nxt  = '0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    err_nxt = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_nxt = add_full[N-1:0];
        c_nxt   = add_full[N];
        v_nxt   = (a_q[N-1] == b_q[N-1]) && (add_full[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        res_nxt = sub_full[N-1:0];
        c_nxt   = sub_full[N];
        v_nxt   = (a_q[N-1] != b_q[N-1]) && (sub_full[N-1] != a_q[N-1]);
      end
      OP_MUL: begin
        res_nxt = iter_lo;
        hi_nxt  = iter_hi;
        v_nxt   = |iter_hi;
      end
      OP_DIV, OP_MOD: begin
        if (div0) begin
          res_nxt = '1;
          hi_nxt  = a_q;
          err_nxt = 1'b1;
        end else begin
          res_nxt = iter_lo;
          hi_nxt  = iter_hi;
        end
      end
      OP_AND: res_nxt = a_q & b_q;
      OP_OR:  res_nxt = a_q | b_q;
      OP_XOR: res_nxt = a_q ^ b_q;
      default: res_nxt = '0;
    endcase
    n_nxt = res_nxt[N-1];
    // Z on MUL looks at the whole 2N-bit product, not just the low half.
    z_nxt = (op_q == OP_MUL) ? ((res_nxt == '0) && (hi_nxt == '0)) : (res_nxt == '0);
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    finish    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!is_iterative(op_q) || div0) begin
          finish = 1'b1;
        end else begin
          step   = 1'b1;
          finish = iter_last;
        end
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        op_q <= op_t'(op);
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err_div0  <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        result    <= res_nxt;
        result_hi <= hi_nxt;
        flag_n    <= n_nxt;
        flag_z    <= z_nxt;
        flag_c    <= c_nxt;
        flag_v    <= v_nxt;
        err_div0  <= err_nxt;
      end
    end
  end

endmodule
